// File: rtl/data_cache_wb.sv
// Write-back, write-allocate, direct-mapped data cache with burst refill/writeback
// to a backing memory and saturating hit/miss counters.
module data_cache_wb #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 3 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, REFILL = 2'd2} state_t;

  state_t           state_r, state_nxt_s;
  logic [OFF_W-1:0] beat_r, beat_nxt_s;
  logic             miss_r, miss_nxt_s;
  logic [IDX_W-1:0] bidx_r;
  logic [TAG_W-1:0] btag_r;
  logic [LINES-1:0] valid_r, dirty_r;
  logic [31:0]      hit_count_r, miss_count_r;
  logic [DATA_W-1:0] data_mem_r [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]  tag_mem_r  [LINES];

  logic [OFF_W-1:0] off_s;
  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic req_s, hit_s, last_beat_s, unused_s;
  logic hit_inc_s, miss_inc_s, wr_hit_s, start_miss_s, fill_we_s, fill_done_s, wb_done_s;

  assign off_s       = cpu_addr[3 +: OFF_W];
  assign idx_s       = cpu_addr[3+OFF_W +: IDX_W];
  assign tag_s       = cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_s    = &{1'b0, cpu_addr[2:0]};
  assign req_s       = cpu_read | cpu_write;
  assign hit_s       = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
  assign last_beat_s = (beat_r == OFF_W'(WORDS_PER_LINE - 1));
  assign hit_count   = hit_count_r;
  assign miss_count  = miss_count_r;

  // Next-state, handshake outputs and array-update strobes.
  always_comb begin
    state_nxt_s  = state_r;
    beat_nxt_s   = beat_r;
    miss_nxt_s   = miss_r;
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    hit_inc_s    = 1'b0;
    miss_inc_s   = 1'b0;
    wr_hit_s     = 1'b0;
    start_miss_s = 1'b0;
    fill_we_s    = 1'b0;
    fill_done_s  = 1'b0;
    wb_done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && hit_s) begin
          cpu_ready  = 1'b1;
          cpu_rdata  = data_mem_r[{idx_s, off_s}];
          wr_hit_s   = cpu_write;
          hit_inc_s  = ~miss_r;
          miss_nxt_s = 1'b0;
        end else if (req_s) begin
          miss_inc_s   = 1'b1;
          miss_nxt_s   = 1'b1;
          start_miss_s = 1'b1;
          state_nxt_s  = (valid_r[idx_s] && dirty_r[idx_s]) ? WRITEBACK : REFILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem_r[bidx_r], bidx_r, beat_r, 3'b000};
        mem_wdata = data_mem_r[{bidx_r, beat_r}];
        if (mem_ack && last_beat_s) begin
          beat_nxt_s  = '0;
          wb_done_s   = 1'b1;
          state_nxt_s = REFILL;
        end else if (mem_ack) begin
          beat_nxt_s = beat_r + OFF_W'(1);
        end else begin
          beat_nxt_s = beat_r;
        end
      end
      REFILL: begin
        mem_req   = 1'b1;
        mem_addr  = {btag_r, bidx_r, beat_r, 3'b000};
        fill_we_s = mem_ack;
        if (mem_ack && last_beat_s) begin
          beat_nxt_s  = '0;
          fill_done_s = 1'b1;
          state_nxt_s = IDLE;
        end else if (mem_ack) begin
          beat_nxt_s = beat_r + OFF_W'(1);
        end else begin
          beat_nxt_s = beat_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control state, line status bits and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      beat_r       <= '0;
      miss_r       <= 1'b0;
      bidx_r       <= '0;
      btag_r       <= '0;
      valid_r      <= '0;
      dirty_r      <= '0;
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      beat_r  <= beat_nxt_s;
      miss_r  <= miss_nxt_s;
      // Burst target is latched so a wandering address cannot touch another line.
      if (start_miss_s) begin
        bidx_r <= idx_s;
        btag_r <= tag_s;
      end
      if (wr_hit_s)    dirty_r[idx_s]  <= 1'b1;
      if (wb_done_s)   dirty_r[bidx_r] <= 1'b0;
      if (fill_done_s) begin
        valid_r[bidx_r] <= 1'b1;
        dirty_r[bidx_r] <= 1'b0;
      end
      if (hit_inc_s && (hit_count_r != 32'hFFFF_FFFF))   hit_count_r  <= hit_count_r + 32'd1;
      if (miss_inc_s && (miss_count_r != 32'hFFFF_FFFF)) miss_count_r <= miss_count_r + 32'd1;
    end
  end

  // Data and tag storage; intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_hit_s)    data_mem_r[{idx_s, off_s}]   <= cpu_wdata;
    if (fill_we_s)   data_mem_r[{bidx_r, beat_r}] <= mem_rdata;
    if (fill_done_s) tag_mem_r[bidx_r]            <= btag_r;
  end
endmodule

// File: tb/tb_data_cache_wb.sv
// Directed bench for data_cache_wb (4 lines x 2 words); backing memory returns
// the beat address as data and every completed beat is logged for checking.
module tb_data_cache_wb;
  logic        clock, reset;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr;
  logic [63:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int wait_cnt;
  int n;
  logic [31:0] log_addr [$];
  logic        log_we   [$];
  logic [63:0] log_data [$];

  data_cache_wb #(.DATA_W(64), .ADDR_W(32), .LINES(4), .WORDS_PER_LINE(2)) dut (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_rdata = {32'd0, mem_addr};
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

  // Ack delay counter and beat log.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 0;
    end else begin
      if (mem_req && mem_ack) begin
        wait_cnt <= 0;
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_data.push_back(mem_wdata);
      end else if (mem_req) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Count edges until cpu_ready rises, bounded.
  task automatic wait_ready(input int max, output int cnt);
    cnt = 0;
    while (!cpu_ready && cnt < max) begin
      step();
      cnt++;
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_data.delete();
  endtask

  task automatic request(input logic rd, input logic wr, input logic [31:0] a, input logic [63:0] d);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    #1;
  endtask

  task automatic idle_bus();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 32'd0; cpu_wdata = 64'd0;
    step(); step();
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_hits", {32'd0, hit_count}, 64'd0);
    chk("rst_misses", {32'd0, miss_count}, 64'd0);
    reset = 1'b0;
    step();
    chk("idle_ready", {63'd0, cpu_ready}, 64'd0);
    chk("idle_rdata", cpu_rdata, 64'd0);

    // Cold read miss at 0x40
    clear_log();
    request(1'b1, 1'b0, 32'h40, 64'd0);
    chk("cold_ready0", {63'd0, cpu_ready}, 64'd0);
    chk("cold_req0", {63'd0, mem_req}, 64'd0);
    step();
    chk("cold_misses", {32'd0, miss_count}, 64'd1);
    chk("cold_req1", {63'd0, mem_req}, 64'd1);
    wait_ready(20, n);
    chk("cold_latency", n, 64'd2);
    chk("cold_ready", {63'd0, cpu_ready}, 64'd1);
    chk("cold_rdata", cpu_rdata, 64'h40);
    chk("cold_beats", log_addr.size(), 64'd2);
    chk("cold_b0", {32'd0, log_addr[0]}, 64'h40);
    chk("cold_b1", {32'd0, log_addr[1]}, 64'h48);
    chk("cold_we", {62'd0, log_we[0], log_we[1]}, 64'd0);
    step();
    idle_bus();
    chk("cold_hits", {32'd0, hit_count}, 64'd0);

    // Hit on the other word of the line
    request(1'b1, 1'b0, 32'h48, 64'd0);
    chk("hit_ready", {63'd0, cpu_ready}, 64'd1);
    chk("hit_rdata", cpu_rdata, 64'h48);
    chk("hit_noreq", {63'd0, mem_req}, 64'd0);
    step();
    idle_bus();
    chk("hit_hits", {32'd0, hit_count}, 64'd1);
    chk("hit_noreq2", {63'd0, mem_req}, 64'd0);

    // Write hit, then conflicting read forces writeback
    request(1'b0, 1'b1, 32'h40, 64'hDEAD);
    chk("whit_ready", {63'd0, cpu_ready}, 64'd1);
    step();
    idle_bus();
    chk("whit_hits", {32'd0, hit_count}, 64'd2);
    clear_log();
    request(1'b1, 1'b0, 32'h80, 64'd0);
    wait_ready(20, n);
    chk("evict_latency", n, 64'd5);
    chk("evict_rdata", cpu_rdata, 64'h80);
    chk("evict_beats", log_addr.size(), 64'd4);
    chk("wb0_addr", {32'd0, log_addr[0]}, 64'h40);
    chk("wb0_data", log_data[0], 64'hDEAD);
    chk("wb1_addr", {32'd0, log_addr[1]}, 64'h48);
    chk("wb1_data", log_data[1], 64'h48);
    chk("wb_we", {62'd0, log_we[0], log_we[1]}, 64'd3);
    chk("rf0_addr", {32'd0, log_addr[2]}, 64'h80);
    chk("rf1_addr", {32'd0, log_addr[3]}, 64'h88);
    chk("rf_we", {62'd0, log_we[2], log_we[3]}, 64'd0);
    step();
    idle_bus();
    chk("evict_misses", {32'd0, miss_count}, 64'd2);
    chk("evict_hits", {32'd0, hit_count}, 64'd2);

    // Slow memory: ack after 3 wait cycles per beat
    ack_delay = 3;
    clear_log();
    request(1'b1, 1'b0, 32'h50, 64'd0);
    step();
    chk("slow_req1", {63'd0, mem_req}, 64'd1);
    chk("slow_addr1", {32'd0, mem_addr}, 64'h50);
    step(); step();
    chk("slow_req3", {63'd0, mem_req}, 64'd1);
    chk("slow_addr3", {32'd0, mem_addr}, 64'h50);
    chk("slow_nobeat", log_addr.size(), 64'd0);
    chk("slow_noready", {63'd0, cpu_ready}, 64'd0);
    step();
    chk("slow_addr4", {32'd0, mem_addr}, 64'h50);
    step();
    chk("slow_addr5", {32'd0, mem_addr}, 64'h58);
    chk("slow_onebeat", log_addr.size(), 64'd1);
    wait_ready(30, n);
    chk("slow_latency", n, 64'd4);
    chk("slow_rdata", cpu_rdata, 64'h50);
    step();
    idle_bus();
    ack_delay = 0;
    chk("slow_misses", {32'd0, miss_count}, 64'd3);

    // Reset aborts a refill after its first beat
    request(1'b1, 1'b0, 32'h60, 64'd0);
    step(); step();
    chk("abort_midburst", {63'd0, mem_req}, 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_req", {63'd0, mem_req}, 64'd0);
    chk("abort_hits", {32'd0, hit_count}, 64'd0);
    chk("abort_misses", {32'd0, miss_count}, 64'd0);
    chk("abort_ready", {63'd0, cpu_ready}, 64'd0);
    idle_bus();
    step();
    reset = 1'b0;
    step();
    chk("post_rst_req", {63'd0, mem_req}, 64'd0);
    request(1'b1, 1'b0, 32'h60, 64'd0);
    chk("remiss_ready", {63'd0, cpu_ready}, 64'd0);
    step();
    chk("remiss_misses", {32'd0, miss_count}, 64'd1);
    wait_ready(20, n);
    chk("remiss_latency", n, 64'd2);
    chk("remiss_rdata", cpu_rdata, 64'h60);
    step();
    idle_bus();

    // Read+write together acts as a write
    request(1'b1, 1'b1, 32'h60, 64'h5);
    chk("rw_ready", {63'd0, cpu_ready}, 64'd1);
    step();
    idle_bus();
    request(1'b1, 1'b0, 32'h60, 64'd0);
    chk("rw_rdata", cpu_rdata, 64'h5);
    step();
    idle_bus();
    chk("rw_hits", {32'd0, hit_count}, 64'd2);
    clear_log();
    request(1'b1, 1'b0, 32'hA0, 64'd0);
    wait_ready(20, n);
    chk("rw_evict_latency", n, 64'd5);
    chk("rw_wb_we", {63'd0, log_we[0]}, 64'd1);
    chk("rw_wb_addr", {32'd0, log_addr[0]}, 64'h60);
    chk("rw_wb_data", log_data[0], 64'h5);
    chk("rw_evict_rdata", cpu_rdata, 64'hA0);
    step();
    idle_bus();
    chk("rw_misses", {32'd0, miss_count}, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
